llc_update_seq: RTL and testbench
=================================

# llc_update_seq

Multi-cycle update sequencer for the LLC. It replaces the single-cycle update stage with a parametrised engine that writes one way back to the LLC arrays after a controller request. It also walks the whole cache on reset and invalidates valid DATA lines of one set on flush, in groups of `GRP` ways per cycle, skipping empty groups. It sits between the LLC controller FSM and the LLC array write ports. All outputs are registered.

## Interface
Parameters:
- `WAYS`, default 16: ways per set (`LLC_WAYS`).
- `SETS`, default 512: sets walked on reset; must be a power of 2.
- `GRP`, default 4: ways written per cycle during reset/flush. `WAYS % GRP == 0`. `NGRP = WAYS/GRP`.

Derived widths: `SET_W=$clog2(SETS)`, `WAY_W=$clog2(WAYS)`, `GRP_W=max(1,$clog2(NGRP))`.

Ports:
- `clk` in 1 — the single clock.
- `rst` in 1 — reset, asynchronous and active-high.
- `req_valid` in 1 — controller request.
- `req_ready` out 1 — the engine is idle and accepts a request.
- `req_op` in 2 — 0 WAY, 1 RST, 2 FLUSH, 3 NOP.
- `req_set` in SET_W — target set for WAY and FLUSH.
- `way` in WAY_W — target way for WAY.
- `update_evict_way` in 1 — WAY only: also write `evict_way_buf`.
- `evict_way_buf` in WAY_W — evict-way value.
- `dirty_bits_buf`, `states_buf`, `hprots_buf`, `lines_buf`, `tags_buf`, `sharers_buf`, `owners_buf` in [WAYS] of the package types — buffered set contents.
- `wr_en` out 1 — single-way write strobe.
- `wr_way` out WAY_W — way written by `wr_en`.
- `wr_set` out SET_W — set for every write.
- `wr_data_tag`, `wr_data_state`, `wr_data_line`, `wr_data_hprot`, `wr_data_owner`, `wr_data_sharers`, `wr_data_dirty_bit` out — write data.
- `wr_en_evict_way` out 1, `wr_data_evict_way` out WAY_W — evict-way write.
- `wr_rst_flush` out GRP — per-way invalidate strobes within the current group.
- `wr_grp` out GRP_W — group index; way = `wr_grp*GRP + i`.
- `done` out 1 — one-cycle pulse at completion.
- `busy` out 1 — `!req_ready`.

## Operation
- States: IDLE, WAY, RST, FLUSH, FIN. `req_ready = (state==IDLE)`.
- Accept happens when `req_valid && req_ready`. Inputs are sampled only at accept. Requests arriving while busy are ignored; the controller holds `req_valid`.
- **WAY**:
  - At accept, snapshot the fields of `way` from the buffers, plus `req_set`, `evict_way_buf` and `update_evict_way`.
  - Next cycle: `wr_en=1`, data = snapshot, `wr_en_evict_way=update_evict_way`, `done=1`. Then return to IDLE.
- **RST**:
  - Set counter and group counter start at 0.
  - Each cycle: `wr_rst_flush` = all ones, `wr_data_state=INVALID`, dirty=0, sharers=0, other data 0.
  - `wr_en_evict_way=1` with `wr_data_evict_way=0` only on group 0 of each set.
  - The group counter increments and wraps to 0 after NGRP-1, which increments the set counter.
  - `done` is asserted with the write of set SETS-1, group NGRP-1.
- **FLUSH**:
  - At accept, capture `mask[w] = (states_buf[w]==VALID && hprots_buf[w]==DATA)`.
  - Each cycle, select the lowest group with a nonzero mask: drive `wr_grp`, set `wr_rst_flush` = that group's mask bits, write INVALID/0 data, then clear those bits.
  - `done` is asserted with the last nonzero group.
  - If the mask is all zero, go to FIN: one cycle with `done=1` and no strobes.
- **NOP**: FIN, i.e. `done` only.
- Outside an active write cycle, every write strobe is 0 and all data is 0.

## Timing
- Accept at cycle T. The first write or `done` appears at T+1.
- `req_ready` rises at the cycle after `done`.
- Latencies:
  - WAY / NOP / empty FLUSH: 1 cycle.
  - FLUSH: k cycles, where k = number of groups with any eligible way (1..NGRP).
  - RST: SETS·NGRP cycles.
- Back-to-back: the earliest next accept is at `done`+1.
- Reset values: all outputs 0 except `req_ready=1`. State is IDLE and counters and mask are 0.
- If `rst` is asserted mid-operation, everything clears immediately (asynchronously). No further strobes are issued, and `done` is not generated for the aborted operation.
- Counter wrap: the set counter wraps only at the RST end. The group counter wraps per set.

## Structure
- Shared package `llc_update_pkg`:
  - `upd_op_t` enum (WAY=0, RST=1, FLUSH=2, NOP=3).
  - `upd_state_t`.
  - Continues to use `llc_state_t`, `hprot_t`, `line_t`, `llc_tag_t`, `sharers_t`, `owner_t` and the constants `VALID`, `INVALID`, `DATA` from the common cache headers.
- Sub-module `llc_grp_pri_enc`:
  - Takes a WAYS-bit mask.
  - Returns the lowest nonzero group index, that group's GRP bits, and `any`.
  - Also returns `last`, meaning no other group is nonzero.

## Test plan
- WAY, way=5, set=17, `update_evict_way=1`, evict=9 → at T+1: `wr_en=1`, `wr_way=5`, `wr_set=17`, data = buffer[5], `wr_en_evict_way=1`, `wr_data_evict_way=9`, `done=1`. `req_ready` is back at T+2.
- RST with SETS=4, GRP=4, WAYS=16 → 16 write cycles with `wr_rst_flush`=4'hF. `wr_en_evict_way` appears only on groups 0 (4 times). `done` is on cycle 16 with set=3, grp=3.
- FLUSH, valid DATA on ways {1, 2, 13} → 2 cycles: grp0 strobe 4'b0110, grp3 strobe 4'b0010 with `done`. Way 6 (valid, INSTR) is untouched.
- FLUSH with no eligible ways, and NOP → `done` at T+1, all strobes 0.
- `rst` asserted at RST cycle 7 → outputs are 0 in the same cycle. After release, `req_ready=1`; a WAY request then completes normally.
- `req_valid` held while busy with a changed `req_op` → ignored until `done`+1, then accepted with the values sampled at that cycle.

Source files
------------

// File: rtl/llc_update_pkg.sv
// Shared types for the LLC update sequencer.
// Cache field types and state/hprot encodings used by the LLC arrays,
// the request opcode and the sequencer state encoding, plus a helper
// that sizes the group index so it never collapses to zero width.
package llc_update_pkg;

   typedef logic [2:0]  llc_state_t;
   typedef logic        hprot_t;
   typedef logic [63:0] line_t;
   typedef logic [19:0] llc_tag_t;
   typedef logic [15:0] sharers_t;
   typedef logic [3:0]  owner_t;

   // INVALID must stay the all-zero encoding: idle cycles drive all data to 0.
   localparam llc_state_t INVALID = 3'd0;
   localparam llc_state_t VALID   = 3'd1;

   localparam hprot_t INSTR = 1'b0;
   localparam hprot_t DATA  = 1'b1;

   typedef enum logic [1:0] {
      WAY   = 2'd0,
      RST   = 2'd1,
      FLUSH = 2'd2,
      NOP   = 2'd3
   } upd_op_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAY   = 3'd1,
      S_RST   = 3'd2,
      S_FLUSH = 3'd3,
      S_FIN   = 3'd4
   } upd_state_t;

   function automatic int grp_width(input int ngrp);
      return (ngrp > 1) ? $clog2(ngrp) : 1;
   endfunction

endpackage

// File: rtl/llc_update_seq_grp_pri_enc.sv
// Group priority encoder for the flush walk.
// Ports:
//   mask  in  WAYS   per-way eligibility
//   grp   out GRP_W  lowest group holding a set bit (0 when mask is empty)
//   bits  out GRP    that group's slice of mask
//   any   out 1      mask is nonzero
//   last  out 1      no group other than grp has a set bit
module llc_grp_pri_enc
   import llc_update_pkg::*;
#(
   parameter  int WAYS  = 16,
   parameter  int GRP   = 4,
   localparam int NGRP  = WAYS / GRP,
   localparam int GRP_W = grp_width(NGRP)
) (
   input  logic [WAYS-1:0]  mask,
   output logic [GRP_W-1:0] grp,
   output logic [GRP-1:0]   bits,
   output logic             any,
   output logic             last
);

   logic [NGRP-1:0] gnz;

   always_comb begin
      gnz = '0;
      for (int g = 0; g < NGRP; g++) begin
         gnz[g] = |mask[g*GRP +: GRP];
      end
      any = |gnz;

      // Walk downward so the lowest nonzero group wins.
      grp = '0;
      for (int g = NGRP - 1; g >= 0; g--) begin
         if (gnz[g]) grp = GRP_W'(g);
      end

      bits = '0;
      for (int g = 0; g < NGRP; g++) begin
         if (GRP_W'(g) == grp) bits = mask[g*GRP +: GRP];
      end

      last = 1'b1;
      for (int g = 0; g < NGRP; g++) begin
         if (gnz[g] && (GRP_W'(g) != grp)) last = 1'b0;
      end
   end

endmodule

// File: rtl/llc_update_seq.sv
// Multi-cycle LLC update sequencer.
// Writes one way back after a controller request, walks every set on RST
// (GRP ways per cycle), and invalidates valid DATA lines of one set on
// FLUSH, skipping empty groups. Every output is a flop.
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_op/req_set/way       opcode, target set, target way
//   update_evict_way,
//   evict_way_buf            optional evict-way write for WAY
//   *_buf [WAYS]             buffered set contents
//   wr_en/wr_way/wr_set      single-way write port (wr_set also for groups)
//   wr_data_*                write data
//   wr_en_evict_way,
//   wr_data_evict_way        evict-way write
//   wr_rst_flush/wr_grp      per-way invalidate strobes for one group
//   done                     one-cycle completion pulse
//   busy                     inverse of req_ready
//
// state   | meaning
// S_IDLE  | ready, waiting for a request
// S_WAY   | single-way write cycle (also done)
// S_RST   | walking set/group counters, invalidating everything
// S_FLUSH | invalidating eligible groups of one set
// S_FIN   | done-only cycle (NOP, empty FLUSH)
module llc_update_seq
   import llc_update_pkg::*;
#(
   parameter  int WAYS  = 16,
   parameter  int SETS  = 512,
   parameter  int GRP   = 4,
   localparam int NGRP  = WAYS / GRP,
   localparam int SET_W = $clog2(SETS),
   localparam int WAY_W = $clog2(WAYS),
   localparam int GRP_W = grp_width(NGRP)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  upd_op_t          req_op,
   input  logic [SET_W-1:0] req_set,
   input  logic [WAY_W-1:0] way,
   input  logic             update_evict_way,
   input  logic [WAY_W-1:0] evict_way_buf,
   input  logic             dirty_bits_buf [WAYS],
   input  llc_state_t       states_buf     [WAYS],
   input  hprot_t           hprots_buf     [WAYS],
   input  line_t            lines_buf      [WAYS],
   input  llc_tag_t         tags_buf       [WAYS],
   input  sharers_t         sharers_buf    [WAYS],
   input  owner_t           owners_buf     [WAYS],
   output logic             wr_en,
   output logic [WAY_W-1:0] wr_way,
   output logic [SET_W-1:0] wr_set,
   output llc_tag_t         wr_data_tag,
   output llc_state_t       wr_data_state,
   output line_t            wr_data_line,
   output hprot_t           wr_data_hprot,
   output owner_t           wr_data_owner,
   output sharers_t         wr_data_sharers,
   output logic             wr_data_dirty_bit,
   output logic             wr_en_evict_way,
   output logic [WAY_W-1:0] wr_data_evict_way,
   output logic [GRP-1:0]   wr_rst_flush,
   output logic [GRP_W-1:0] wr_grp,
   output logic             done,
   output logic             busy
);

   upd_state_t       state_q, state_d;
   logic [SET_W-1:0] set_q, set_d;
   logic [GRP_W-1:0] grp_q, grp_d;
   logic [SET_W-1:0] fset_q, fset_d;
   logic [WAYS-1:0]  mask_q, mask_d;
   logic [WAYS-1:0]  flush_mask;
   logic [WAYS-1:0]  clr;

   logic [GRP_W-1:0] enc_grp;
   logic [GRP-1:0]   enc_bits;
   logic             enc_any;
   logic             enc_last;

   logic             req_ready_d, wr_en_d, wr_en_evict_way_d, done_d;
   logic [WAY_W-1:0] wr_way_d, wr_data_evict_way_d;
   logic [SET_W-1:0] wr_set_d;
   llc_tag_t         wr_data_tag_d;
   llc_state_t       wr_data_state_d;
   line_t            wr_data_line_d;
   hprot_t           wr_data_hprot_d;
   owner_t           wr_data_owner_d;
   sharers_t         wr_data_sharers_d;
   logic             wr_data_dirty_bit_d;
   logic [GRP-1:0]   wr_rst_flush_d;
   logic [GRP_W-1:0] wr_grp_d;

   always_comb begin
      flush_mask = '0;
      for (int w = 0; w < WAYS; w++) begin
         flush_mask[w] = (states_buf[w] == VALID) && (hprots_buf[w] == DATA);
      end
   end

   // Bits invalidated by the strobe currently on the outputs.
   always_comb begin
      clr = '0;
      for (int i = 0; i < WAYS; i++) begin
         if ((GRP_W'(i / GRP) == wr_grp) && wr_rst_flush[i % GRP]) clr[i] = 1'b1;
      end
   end

   // The encoder looks at the mask that will be live next cycle, so its
   // result can be registered straight onto the outputs.
   llc_grp_pri_enc #(
      .WAYS (WAYS),
      .GRP  (GRP)
   ) u_pri_enc (
      .mask (mask_d),
      .grp  (enc_grp),
      .bits (enc_bits),
      .any  (enc_any),
      .last (enc_last)
   );

   // Next state, counters and flush mask. The registered done flag marks
   // the final cycle of every operation, so it alone drives the return to IDLE.
   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      grp_d   = grp_q;
      fset_d  = fset_q;
      mask_d  = mask_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               case (req_op)
                  WAY: state_d = S_WAY;
                  RST: begin
                     state_d = S_RST;
                     set_d   = '0;
                     grp_d   = '0;
                  end
                  FLUSH: begin
                     mask_d  = flush_mask;
                     fset_d  = req_set;
                     state_d = (|flush_mask) ? S_FLUSH : S_FIN;
                  end
                  default: state_d = S_FIN;
               endcase
            end
         end
         S_RST: begin
            if (done) begin
               state_d = S_IDLE;
               set_d   = '0;
               grp_d   = '0;
            end else if (grp_q == GRP_W'(NGRP - 1)) begin
               grp_d = '0;
               set_d = set_q + 1'b1;
            end else begin
               grp_d = grp_q + 1'b1;
            end
         end
         S_FLUSH: begin
            if (done) begin
               state_d = S_IDLE;
               mask_d  = '0;
            end else begin
               mask_d = mask_q & ~clr;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output values for the cycle being entered.
   always_comb begin
      req_ready_d         = (state_d == S_IDLE);
      wr_en_d             = 1'b0;
      wr_way_d            = '0;
      wr_set_d            = '0;
      wr_data_tag_d       = '0;
      wr_data_state_d     = INVALID;
      wr_data_line_d      = '0;
      wr_data_hprot_d     = '0;
      wr_data_owner_d     = '0;
      wr_data_sharers_d   = '0;
      wr_data_dirty_bit_d = 1'b0;
      wr_en_evict_way_d   = 1'b0;
      wr_data_evict_way_d = '0;
      wr_rst_flush_d      = '0;
      wr_grp_d            = '0;
      done_d              = 1'b0;
      case (state_d)
         S_WAY: begin
            wr_en_d             = 1'b1;
            wr_way_d            = way;
            wr_set_d            = req_set;
            wr_data_tag_d       = tags_buf[way];
            wr_data_state_d     = states_buf[way];
            wr_data_line_d      = lines_buf[way];
            wr_data_hprot_d     = hprots_buf[way];
            wr_data_owner_d     = owners_buf[way];
            wr_data_sharers_d   = sharers_buf[way];
            wr_data_dirty_bit_d = dirty_bits_buf[way];
            wr_en_evict_way_d   = update_evict_way;
            wr_data_evict_way_d = update_evict_way ? evict_way_buf : '0;
            done_d              = 1'b1;
         end
         S_RST: begin
            wr_set_d          = set_d;
            wr_grp_d          = grp_d;
            wr_rst_flush_d    = '1;
            wr_en_evict_way_d = (grp_d == '0);
            done_d            = (set_d == SET_W'(SETS - 1)) && (grp_d == GRP_W'(NGRP - 1));
         end
         S_FLUSH: begin
            wr_set_d       = fset_d;
            wr_grp_d       = enc_grp;
            wr_rst_flush_d = enc_bits;
            done_d         = enc_any && enc_last;
         end
         S_FIN: done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= S_IDLE;
         set_q             <= '0;
         grp_q             <= '0;
         fset_q            <= '0;
         mask_q            <= '0;
         req_ready         <= 1'b1;
         busy              <= 1'b0;
         wr_en             <= 1'b0;
         wr_way            <= '0;
         wr_set            <= '0;
         wr_data_tag       <= '0;
         wr_data_state     <= INVALID;
         wr_data_line      <= '0;
         wr_data_hprot     <= '0;
         wr_data_owner     <= '0;
         wr_data_sharers   <= '0;
         wr_data_dirty_bit <= 1'b0;
         wr_en_evict_way   <= 1'b0;
         wr_data_evict_way <= '0;
         wr_rst_flush      <= '0;
         wr_grp            <= '0;
         done              <= 1'b0;
      end else begin
         state_q           <= state_d;
         set_q             <= set_d;
         grp_q             <= grp_d;
         fset_q            <= fset_d;
         mask_q            <= mask_d;
         req_ready         <= req_ready_d;
         busy              <= ~req_ready_d;
         wr_en             <= wr_en_d;
         wr_way            <= wr_way_d;
         wr_set            <= wr_set_d;
         wr_data_tag       <= wr_data_tag_d;
         wr_data_state     <= wr_data_state_d;
         wr_data_line      <= wr_data_line_d;
         wr_data_hprot     <= wr_data_hprot_d;
         wr_data_owner     <= wr_data_owner_d;
         wr_data_sharers   <= wr_data_sharers_d;
         wr_data_dirty_bit <= wr_data_dirty_bit_d;
         wr_en_evict_way   <= wr_en_evict_way_d;
         wr_data_evict_way <= wr_data_evict_way_d;
         wr_rst_flush      <= wr_rst_flush_d;
         wr_grp            <= wr_grp_d;
         done              <= done_d;
      end
   end

endmodule

// File: tb/tb_llc_update_seq.sv
// Directed bench for llc_update_seq (WAYS=16, SETS=32, GRP=4).
module tb_llc_update_seq;
   import llc_update_pkg::*;

   localparam int WAYS  = 16;
   localparam int SETS  = 32;
   localparam int GRP   = 4;
   localparam int SET_W = 5;
   localparam int WAY_W = 4;
   localparam int GRP_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   upd_op_t          req_op;
   logic [SET_W-1:0] req_set;
   logic [WAY_W-1:0] way;
   logic             update_evict_way;
   logic [WAY_W-1:0] evict_way_buf;
   logic             dirty_bits_buf [WAYS];
   llc_state_t       states_buf     [WAYS];
   hprot_t           hprots_buf     [WAYS];
   line_t            lines_buf      [WAYS];
   llc_tag_t         tags_buf       [WAYS];
   sharers_t         sharers_buf    [WAYS];
   owner_t           owners_buf     [WAYS];
   logic             wr_en;
   logic [WAY_W-1:0] wr_way;
   logic [SET_W-1:0] wr_set;
   llc_tag_t         wr_data_tag;
   llc_state_t       wr_data_state;
   line_t            wr_data_line;
   hprot_t           wr_data_hprot;
   owner_t           wr_data_owner;
   sharers_t         wr_data_sharers;
   logic             wr_data_dirty_bit;
   logic             wr_en_evict_way;
   logic [WAY_W-1:0] wr_data_evict_way;
   logic [GRP-1:0]   wr_rst_flush;
   logic [GRP_W-1:0] wr_grp;
   logic             done;
   logic             busy;

   int total = 0;
   int bad   = 0;

   llc_update_seq #(.WAYS(WAYS), .SETS(SETS), .GRP(GRP)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_op            (req_op),
      .req_set           (req_set),
      .way               (way),
      .update_evict_way  (update_evict_way),
      .evict_way_buf     (evict_way_buf),
      .dirty_bits_buf    (dirty_bits_buf),
      .states_buf        (states_buf),
      .hprots_buf        (hprots_buf),
      .lines_buf         (lines_buf),
      .tags_buf          (tags_buf),
      .sharers_buf       (sharers_buf),
      .owners_buf        (owners_buf),
      .wr_en             (wr_en),
      .wr_way            (wr_way),
      .wr_set            (wr_set),
      .wr_data_tag       (wr_data_tag),
      .wr_data_state     (wr_data_state),
      .wr_data_line      (wr_data_line),
      .wr_data_hprot     (wr_data_hprot),
      .wr_data_owner     (wr_data_owner),
      .wr_data_sharers   (wr_data_sharers),
      .wr_data_dirty_bit (wr_data_dirty_bit),
      .wr_en_evict_way   (wr_en_evict_way),
      .wr_data_evict_way (wr_data_evict_way),
      .wr_rst_flush      (wr_rst_flush),
      .wr_grp            (wr_grp),
      .done              (done),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic issue(input upd_op_t op, input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w,
                        input logic uev, input logic [WAY_W-1:0] ev);
      @(negedge clk);
      req_op           = op;
      req_set          = s;
      way              = w;
      update_evict_way = uev;
      evict_way_buf    = ev;
      req_valid        = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic set_eligible(input logic on);
      states_buf[1]  = on ? VALID : 3'd2;
      states_buf[2]  = on ? VALID : 3'd2;
      states_buf[13] = on ? VALID : 3'd2;
      hprots_buf[1]  = DATA;
      hprots_buf[2]  = DATA;
      hprots_buf[13] = DATA;
   endtask

   initial begin
      int nf, nev, dcyc, seqbad, late;
      logic [SET_W-1:0] dset;
      logic [GRP_W-1:0] dgrp;

      rst = 1'b1;
      req_valid = 1'b0;
      req_op = NOP;
      req_set = '0;
      way = '0;
      update_evict_way = 1'b0;
      evict_way_buf = '0;
      for (int w = 0; w < WAYS; w++) begin
         tags_buf[w]       = 20'hA0000 + 20'(w);
         lines_buf[w]      = 64'hDEAD_0000_0000_0000 + 64'(w);
         owners_buf[w]     = 4'(w) ^ 4'hF;
         sharers_buf[w]    = 16'(1) << w;
         dirty_bits_buf[w] = 1'(w % 2);
         states_buf[w]     = 3'd2;
         hprots_buf[w]     = INSTR;
      end
      // way 6: valid instruction line, never eligible; way 9: data but not valid
      states_buf[6] = VALID;
      hprots_buf[9] = DATA;

      repeat (2) @(negedge clk);
      chk("reset_ready", req_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_wr_en", wr_en, 0);
      chk("reset_flush", wr_rst_flush, 0);
      chk("reset_evict", wr_en_evict_way, 0);
      rst = 1'b0;

      // single-way write
      issue(WAY, 5'd17, 4'd5, 1'b1, 4'd9);
      @(negedge clk);
      chk("way_wr_en", wr_en, 1);
      chk("way_wr_way", wr_way, 5);
      chk("way_wr_set", wr_set, 17);
      chk("way_tag", wr_data_tag, 20'hA0005);
      chk("way_line", wr_data_line, 64'hDEAD_0000_0000_0005);
      chk("way_state", wr_data_state, 2);
      chk("way_hprot", wr_data_hprot, 0);
      chk("way_owner", wr_data_owner, 4'hA);
      chk("way_sharers", wr_data_sharers, 16'h0020);
      chk("way_dirty", wr_data_dirty_bit, 1);
      chk("way_ev_en", wr_en_evict_way, 1);
      chk("way_ev_data", wr_data_evict_way, 9);
      chk("way_done", done, 1);
      chk("way_ready_busy", req_ready, 0);
      @(negedge clk);
      chk("way_ready_back", req_ready, 1);
      chk("way_idle_wr_en", wr_en, 0);
      chk("way_idle_tag", wr_data_tag, 0);
      chk("way_idle_done", done, 0);

      // full reset walk: 32 sets x 4 groups
      issue(RST, 5'd0, 4'd0, 1'b0, 4'd0);
      nf = 0; nev = 0; dcyc = 0; seqbad = 0; dset = '0; dgrp = '0;
      for (int c = 1; c <= 200 && dcyc == 0; c++) begin
         @(negedge clk);
         if (wr_rst_flush == 4'hF) nf++;
         if (wr_en_evict_way) nev++;
         if (wr_set != 5'((c - 1) / 4) || wr_grp != 2'((c - 1) % 4) || wr_en) seqbad++;
         if (wr_en_evict_way && wr_grp != 2'd0) seqbad++;
         if (wr_data_state != INVALID || wr_data_sharers != 0 || wr_data_evict_way != 0) seqbad++;
         if (done) begin
            dcyc = c;
            dset = wr_set;
            dgrp = wr_grp;
         end
      end
      chk("rst_done_cycle", dcyc, 128);
      chk("rst_flush_cycles", nf, 128);
      chk("rst_evict_count", nev, 32);
      chk("rst_sequence", seqbad, 0);
      chk("rst_done_set", dset, 31);
      chk("rst_done_grp", dgrp, 3);
      @(negedge clk);
      chk("rst_ready_back", req_ready, 1);
      chk("rst_idle_flush", wr_rst_flush, 0);

      // flush of ways 1, 2, 13
      set_eligible(1'b1);
      issue(FLUSH, 5'd7, 4'd0, 1'b0, 4'd0);
      @(negedge clk);
      chk("fl_g0_grp", wr_grp, 0);
      chk("fl_g0_strobe", wr_rst_flush, 4'b0110);
      chk("fl_g0_set", wr_set, 7);
      chk("fl_g0_done", done, 0);
      chk("fl_g0_evict", wr_en_evict_way, 0);
      @(negedge clk);
      chk("fl_g3_grp", wr_grp, 3);
      chk("fl_g3_strobe", wr_rst_flush, 4'b0010);
      chk("fl_g3_done", done, 1);
      @(negedge clk);
      chk("fl_after_strobe", wr_rst_flush, 0);
      chk("fl_after_ready", req_ready, 1);

      // flush with nothing eligible
      set_eligible(1'b0);
      issue(FLUSH, 5'd3, 4'd0, 1'b0, 4'd0);
      @(negedge clk);
      chk("fl0_done", done, 1);
      chk("fl0_strobe", wr_rst_flush, 0);
      chk("fl0_wr_en", wr_en, 0);
      @(negedge clk);
      chk("fl0_ready", req_ready, 1);
      chk("fl0_done_gone", done, 0);

      // NOP
      issue(NOP, 5'd0, 4'd0, 1'b0, 4'd0);
      @(negedge clk);
      chk("nop_done", done, 1);
      chk("nop_strobe", wr_rst_flush, 0);
      chk("nop_evict", wr_en_evict_way, 0);
      @(negedge clk);
      chk("nop_ready", req_ready, 1);

      // reset mid-walk
      issue(RST, 5'd0, 4'd0, 1'b0, 4'd0);
      repeat (7) @(negedge clk);
      chk("abort_active", wr_rst_flush, 4'hF);
      rst = 1'b1;
      #1;
      chk("abort_flush", wr_rst_flush, 0);
      chk("abort_done", done, 0);
      chk("abort_set", wr_set, 0);
      chk("abort_ready", req_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      late = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || wr_rst_flush != 0 || wr_en_evict_way) late++;
      end
      chk("abort_quiet", late, 0);
      issue(WAY, 5'd4, 4'd2, 1'b0, 4'd7);
      @(negedge clk);
      chk("abort_way_en", wr_en, 1);
      chk("abort_way_way", wr_way, 2);
      chk("abort_way_set", wr_set, 4);
      chk("abort_way_tag", wr_data_tag, 20'hA0002);
      chk("abort_way_ev_en", wr_en_evict_way, 0);
      chk("abort_way_ev", wr_data_evict_way, 0);
      chk("abort_way_done", done, 1);

      // request held across a busy flush with changed fields
      set_eligible(1'b1);
      @(negedge clk);
      req_op    = FLUSH;
      req_set   = 5'd11;
      req_valid = 1'b1;
      @(negedge clk);
      chk("hold_g0_strobe", wr_rst_flush, 4'b0110);
      req_op           = WAY;
      way              = 4'd3;
      req_set          = 5'd9;
      update_evict_way = 1'b1;
      evict_way_buf    = 4'd12;
      @(negedge clk);
      chk("hold_g3_done", done, 1);
      chk("hold_g3_set", wr_set, 11);
      chk("hold_g3_no_way", wr_en, 0);
      @(negedge clk);
      chk("hold_ready", req_ready, 1);
      chk("hold_idle_wr_en", wr_en, 0);
      @(negedge clk);
      chk("hold_way_en", wr_en, 1);
      chk("hold_way_way", wr_way, 3);
      chk("hold_way_set", wr_set, 9);
      chk("hold_way_ev", wr_data_evict_way, 12);
      chk("hold_way_done", done, 1);
      req_valid = 1'b0;
      @(negedge clk);
      chk("hold_end_ready", req_ready, 1);
      chk("hold_end_wr_en", wr_en, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
